ififo_rd_sched: RTL

- Read scheduler for the inbound FIFO path.
- Watches the producer write pointer and the free space in the downstream staging FIFO ("bfifo").
- Issues single-word reads from the main FIFO RAM ("afifo") in bounded bursts and advances the read pointer.
- Returns consumed-word credits to the producer as a toggling ack clock plus an ack length.

---
 rtl/ififo_rd_sched_if.sv | 38 +++
 rtl/ififo_rd_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ififo_rd_sched_if.sv
// Handshake bundle between the inbound read scheduler and its producer/FIFO neighbours.
// stall_cnt is present only when IFIFO_RD_SCHED_STATS_EN is defined.
interface ififo_rd_sched_if #(
    parameter int PTR_W = 17,
    parameter int LEN_W = 18
);
    logic             enable;
    logic [PTR_W-1:0] wptr;
    logic [4:0]       b_space;
    logic             rd_en;
    logic [PTR_W-2:0] rd_addr;
    logic             b_wr;
    logic [PTR_W-1:0] rptr;
    logic             ack_clk;
    logic [LEN_W-1:0] ack_len;
    logic             idle;
`ifdef IFIFO_RD_SCHED_STATS_EN
    logic [31:0]      stall_cnt;

    modport master (
        output enable, wptr, b_space,
        input  rd_en, rd_addr, b_wr, rptr, ack_clk, ack_len, idle, stall_cnt
    );
    modport slave (
        input  enable, wptr, b_space,
        output rd_en, rd_addr, b_wr, rptr, ack_clk, ack_len, idle, stall_cnt
    );
`else
    modport master (
        output enable, wptr, b_space,
        input  rd_en, rd_addr, b_wr, rptr, ack_clk, ack_len, idle
    );
    modport slave (
        input  enable, wptr, b_space,
        output rd_en, rd_addr, b_wr, rptr, ack_clk, ack_len, idle
    );
`endif
endinterface

// File: rtl/ififo_rd_sched.sv
// Inbound FIFO read scheduler: bursts afifo reads into bfifo and returns consumed-word credits.
// Define IFIFO_RD_SCHED_STATS_EN to add the saturating stall_cnt output.
module ififo_rd_sched #(
    parameter int PTR_W       = 17,
    parameter int LEN_W       = 18,
    parameter int RD_LAT      = 2,
    parameter int BURST_MAX   = 16,
    parameter int ACK_THRESH  = 256,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    ififo_rd_sched_if.slave bus
);
    localparam int IFL_W = $clog2(RD_LAT + 1);
    localparam int BST_W = $clog2(BURST_MAX + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [PTR_W-1:0] r_rptr;
    logic [RD_LAT:1]  r_vld_pipe;
    logic [BST_W-1:0] r_burst;
    logic [LEN_W-1:0] r_count;
    logic [TMR_W-1:0] r_timer;
    logic             r_ack_clk;
    logic [LEN_W-1:0] r_ack_len;
    logic             r_idle;

    logic [PTR_W-1:0] w_avail;
    logic             w_has_data;
    logic [IFL_W-1:0] w_inflight;
    logic             w_credit_ok;
    logic             w_issue;
    logic             w_bwr;
    logic [LEN_W-1:0] w_count_nxt;
    logic             w_ack;

    assign w_avail    = bus.wptr - r_rptr;
    assign w_has_data = |w_avail;

    // Every stage of the latency pipe, including the b_wr stage, is a read still in flight.
    always_comb begin
        w_inflight = '0;
        for (int i = 1; i <= RD_LAT; i++)
            w_inflight = w_inflight + IFL_W'(r_vld_pipe[i]);
    end

    // credit = b_space - inflight > 0, done as an unsigned compare
    assign w_credit_ok = {3'b000, bus.b_space} > 8'(w_inflight);
    assign w_issue     = (r_state == S_RUN) && bus.enable && w_has_data && w_credit_ok &&
                         (r_burst < BST_W'(BURST_MAX));
    assign w_bwr       = r_vld_pipe[RD_LAT];
    assign w_count_nxt = r_count + LEN_W'(w_bwr);
    assign w_ack       = (w_count_nxt >= LEN_W'(ACK_THRESH)) ||
                         ((r_timer == TMR_W'(ACK_TIMEOUT)) && (r_count != '0)) ||
                         ((r_state == S_FLUSH) && (w_count_nxt != '0));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.enable && w_has_data)
                    w_state_nxt = S_RUN;
                else if (!bus.enable && ((r_count != '0) || (w_inflight != '0)))
                    w_state_nxt = S_DRAIN;
            end
            S_RUN: begin
                if (!bus.enable)
                    w_state_nxt = S_DRAIN;
                else if (!w_has_data && !w_issue)
                    w_state_nxt = S_IDLE;
            end
            S_DRAIN: if (w_inflight == '0) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rptr     <= '0;
            r_vld_pipe <= '0;
            r_burst    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_vld_pipe[1] <= w_issue;
            for (int i = 2; i <= RD_LAT; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            if (w_issue) begin
                r_rptr  <= r_rptr + PTR_W'(1);
                r_burst <= r_burst + BST_W'(1);
            end else begin
                r_burst <= '0;
            end
        end
    end

    // Credit return: ack_len carries the count including a same-cycle b_wr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_timer   <= '0;
            r_ack_clk <= 1'b0;
            r_ack_len <= '0;
            r_idle    <= 1'b0;
        end else begin
            r_idle <= (r_state == S_IDLE) && (w_inflight == '0) && (r_count == '0);
            if (w_ack) begin
                r_ack_len <= w_count_nxt;
                r_ack_clk <= ~r_ack_clk;
                r_count   <= '0;
            end else begin
                r_count   <= w_count_nxt;
            end
            if (w_ack || w_bwr)
                r_timer <= '0;
            else if (r_count != '0)
                r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign bus.rd_en   = w_issue;
    assign bus.rd_addr = r_rptr[PTR_W-2:0];
    assign bus.b_wr    = w_bwr;
    assign bus.rptr    = r_rptr;
    assign bus.ack_clk = r_ack_clk;
    assign bus.ack_len = r_ack_len;
    assign bus.idle    = r_idle;

`ifdef IFIFO_RD_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if ((r_state == S_RUN) && w_has_data && !w_credit_ok && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
